// File: rtl/ysyx_22040127_fetch_if.sv
// IF-stage port bundle: ID handshake, redirect inputs and the instruction-memory
// request/response channel. The fetch stage connects through the master modport.
// The optional perf counters appear only when FETCH_PERF_EN is defined.
`ifndef IF_TO_ID_WIDTH
`define IF_TO_ID_WIDTH 65
`endif

interface ysyx_22040127_fetch_if;
  logic                       id_allowin;
  logic                       id_branch_taken;
  logic [31:0]                id_branch_result;
  logic                       csr_redirect_valid;
  logic [31:0]                csr_redirect_pc;
  logic                       imem_req_valid;
  logic                       imem_req_ready;
  logic [31:0]                imem_addr;
  logic                       imem_resp_valid;
  logic [31:0]                imem_resp_data;
  logic                       if_to_id_valid;
  logic [`IF_TO_ID_WIDTH-1:0] if_to_id_bus;
  logic [31:0]                if_instruction_reg;
  logic                       if_instruction_blocked;
  logic                       if_flush;
`ifdef FETCH_PERF_EN
  logic [63:0]                perf_fetch_cnt;
  logic [63:0]                perf_stall_cnt;
  logic [63:0]                perf_redirect_cnt;
`endif

  modport master (
`ifdef FETCH_PERF_EN
    output perf_fetch_cnt, perf_stall_cnt, perf_redirect_cnt,
`endif
    input  id_allowin, id_branch_taken, id_branch_result,
    input  csr_redirect_valid, csr_redirect_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output imem_req_valid, imem_addr,
    output if_to_id_valid, if_to_id_bus, if_instruction_reg,
    output if_instruction_blocked, if_flush
  );

  modport slave (
`ifdef FETCH_PERF_EN
    input  perf_fetch_cnt, perf_stall_cnt, perf_redirect_cnt,
`endif
    output id_allowin, id_branch_taken, id_branch_result,
    output csr_redirect_valid, csr_redirect_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  imem_req_valid, imem_addr,
    input  if_to_id_valid, if_to_id_bus, if_instruction_reg,
    input  if_instruction_blocked, if_flush
  );
endinterface

// File: rtl/ysyx_22040127_fetch.sv
// IF stage of the RV64 pipeline: owns the PC, keeps one instruction-memory
// request in flight, buffers the returned word while decode stalls and applies
// branch / CSR redirects. Optional macro FETCH_PERF_EN adds perf counters.
`ifndef IF_TO_ID_WIDTH
`define IF_TO_ID_WIDTH 65
`endif

module ysyx_22040127_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter int          IF_TO_ID_WIDTH = `IF_TO_ID_WIDTH
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_22040127_fetch_if.master  fif
);

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic        started_reg;
  logic        flush_reg;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        out_valid;
  logic        handoff;
  logic [31:0] inst_sel;
  logic [IF_TO_ID_WIDTH-1:0] bus_word;

  // A CSR redirect outranks a decode branch; targets are forced word aligned.
  always_comb begin
    redirect    = fif.csr_redirect_valid | (fif.id_branch_taken & fif.id_allowin);
    redirect_pc = (fif.csr_redirect_valid ? fif.csr_redirect_pc : fif.id_branch_result)
                  & ~32'h3;
  end

  // Next-state, next-pc and handshake outputs of the fetch FSM.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = redirect ? 32'h0 : inst_reg;
    req_valid  = 1'b0;
    out_valid  = 1'b0;
    handoff    = 1'b0;
    inst_sel   = fif.imem_resp_data;
    case (state_reg)
      S_REQ: begin
        // Request only once the first edge after reset release has passed.
        req_valid = started_reg;
        if (redirect) begin
          pc_next    = redirect_pc;
          // If memory took the old address this cycle its answer is stale.
          state_next = (req_valid && fif.imem_req_ready) ? S_DROP : S_REQ;
        end else if (req_valid && fif.imem_req_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fif.imem_resp_valid) begin
          if (redirect) begin
            pc_next    = redirect_pc;
            state_next = S_REQ;
          end else begin
            out_valid = 1'b1;
            if (fif.id_allowin) begin
              handoff    = 1'b1;
              pc_next    = pc_reg + 32'd4;
              state_next = S_REQ;
            end else begin
              inst_next  = fif.imem_resp_data;
              state_next = S_HOLD;
            end
          end
        end else if (redirect) begin
          pc_next    = redirect_pc;
          state_next = S_DROP;
        end
      end
      S_HOLD: begin
        inst_sel = inst_reg;
        if (redirect) begin
          pc_next    = redirect_pc;
          state_next = S_REQ;
        end else begin
          out_valid = 1'b1;
          if (fif.id_allowin) begin
            handoff    = 1'b1;
            pc_next    = pc_reg + 32'd4;
            state_next = S_REQ;
          end
        end
      end
      S_DROP: begin
        if (redirect) begin
          pc_next = redirect_pc;
        end
        if (fif.imem_resp_valid) begin
          state_next = S_REQ;
        end
      end
      default: state_next = S_REQ;
    endcase
  end

  // State, PC, instruction buffer, start flag and flush pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_REQ;
      pc_reg      <= RESET_PC;
      inst_reg    <= 32'h0;
      started_reg <= 1'b0;
      flush_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      inst_reg    <= inst_next;
      started_reg <= 1'b1;
      flush_reg   <= fif.csr_redirect_valid;
    end
  end

  // The bus is zero whenever it carries no live instruction.
  always_comb begin
    bus_word = out_valid ? {(inst_sel == EBREAK_INST), inst_sel, pc_reg} : '0;
  end

  assign fif.imem_req_valid         = req_valid;
  assign fif.imem_addr              = pc_reg;
  assign fif.if_to_id_valid         = out_valid;
  assign fif.if_to_id_bus           = bus_word;
  assign fif.if_instruction_reg     = inst_reg;
  assign fif.if_instruction_blocked = (state_reg == S_HOLD);
  assign fif.if_flush               = flush_reg;

`ifdef FETCH_PERF_EN
  logic [63:0] perf_fetch_reg;
  logic [63:0] perf_stall_reg;
  logic [63:0] perf_redirect_reg;

  // Count handoffs to decode, cycles spent holding, and applied redirects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_reg    <= 64'd0;
      perf_stall_reg    <= 64'd0;
      perf_redirect_reg <= 64'd0;
    end else begin
      if (handoff)              perf_fetch_reg    <= perf_fetch_reg + 64'd1;
      if (state_reg == S_HOLD)  perf_stall_reg    <= perf_stall_reg + 64'd1;
      if (redirect)             perf_redirect_reg <= perf_redirect_reg + 64'd1;
    end
  end

  assign fif.perf_fetch_cnt    = perf_fetch_reg;
  assign fif.perf_stall_cnt    = perf_stall_reg;
  assign fif.perf_redirect_cnt = perf_redirect_reg;
`endif

endmodule

// File: tb/tb_ysyx_22040127_fetch.sv
// Bench for the IF stage: a memory responder with adjustable latency, a
// program-order model of the fetch stream checked every cycle, and directed
// scenarios with literal expectations.
`timescale 1ns/1ps

module tb_ysyx_22040127_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_22040127_fetch_if fif();

  ysyx_22040127_fetch #(.RESET_PC(RESET_PC), .IF_TO_ID_WIDTH(65)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  int checks = 0;
  int errors = 0;

  // Memory image: two fixed words, the rest derived from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0013;
    if (a == 32'h8000_0008) return EBREAK;
    return {a[19:2], 14'h0033};
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Program-order model state (written only by the compare process).
  logic [31:0] m_pc;
  logic        m_out, m_stale, m_buf, m_started, m_flush;
  logic        fire_last = 1'b0;
  logic [31:0] fire_addr_last = 32'h0;
  logic [31:0] addr_log[$];
  logic [64:0] hand_log[$];

  // Compare process: check every cycle against the model, then advance it.
  initial begin
    logic        redir, fresh, exp_valid, exp_req, fire;
    logic [31:0] target, w;
    forever begin
      @(negedge clk);
      fire           = fif.imem_req_valid & fif.imem_req_ready;
      fire_last      = fire;
      fire_addr_last = fif.imem_addr;
      if (rst !== 1'b1) begin
        m_pc = RESET_PC; m_out = 0; m_stale = 0; m_buf = 0; m_started = 0; m_flush = 0;
        chk("rst_req_valid", {64'h0, fif.imem_req_valid}, 65'h0);
        chk("rst_addr", {33'h0, fif.imem_addr}, {33'h0, RESET_PC});
        chk("rst_out_valid", {64'h0, fif.if_to_id_valid}, 65'h0);
        chk("rst_bus", fif.if_to_id_bus, 65'h0);
        chk("rst_inst_reg", {33'h0, fif.if_instruction_reg}, 65'h0);
        chk("rst_blocked", {64'h0, fif.if_instruction_blocked}, 65'h0);
        chk("rst_flush", {64'h0, fif.if_flush}, 65'h0);
      end else begin
        redir     = fif.csr_redirect_valid | (fif.id_branch_taken & fif.id_allowin);
        target    = (fif.csr_redirect_valid ? fif.csr_redirect_pc : fif.id_branch_result);
        target[1:0] = 2'b00;
        fresh     = fif.imem_resp_valid && m_out && !m_stale;
        exp_valid = !redir && (m_buf || fresh);
        exp_req   = m_started && !m_out && !m_buf;
        w         = mem_word(m_pc);
        chk("req_valid", {64'h0, fif.imem_req_valid}, {64'h0, exp_req});
        if (exp_req) chk("req_addr", {33'h0, fif.imem_addr}, {33'h0, m_pc});
        chk("out_valid", {64'h0, fif.if_to_id_valid}, {64'h0, exp_valid});
        if (exp_valid) chk("bus", fif.if_to_id_bus, {(w == EBREAK), w, m_pc});
        chk("blocked", {64'h0, fif.if_instruction_blocked}, {64'h0, m_buf});
        if (m_buf) chk("inst_reg", {33'h0, fif.if_instruction_reg}, {33'h0, w});
        chk("flush", {64'h0, fif.if_flush}, {64'h0, m_flush});
        if (fif.if_to_id_valid && fif.id_allowin) hand_log.push_back(fif.if_to_id_bus);
        if (fire) addr_log.push_back(fif.imem_addr);
        // Advance program order: deliver, drain the buffer, redirect, issue.
        if (fresh && !redir) begin
          if (fif.id_allowin) m_pc = m_pc + 32'd4;
          else                m_buf = 1'b1;
        end else if (m_buf && fif.id_allowin && !redir) begin
          m_buf = 1'b0;
          m_pc  = m_pc + 32'd4;
        end
        if (fif.imem_resp_valid && m_out) begin m_out = 1'b0; m_stale = 1'b0; end
        if (redir) begin
          m_pc  = target;
          m_buf = 1'b0;
          if (m_out) m_stale = 1'b1;
        end
        if (fire) begin m_out = 1'b1; m_stale = redir; end
        m_flush   = fif.csr_redirect_valid;
        m_started = 1'b1;
      end
    end
  end

  // Memory responder: answers each accepted request resp_lat cycles later.
  int          resp_lat = 1;
  int          resp_cnt = 0;
  logic [31:0] resp_addr = 32'h0;
  initial begin
    fif.imem_resp_valid = 1'b0;
    fif.imem_resp_data  = 32'h0;
    forever begin
      @(posedge clk); #1;
      fif.imem_resp_valid = 1'b0;
      if (fire_last) begin resp_cnt = resp_lat; resp_addr = fire_addr_last; end
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          fif.imem_resp_valid = 1'b1;
          fif.imem_resp_data  = mem_word(resp_addr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    addr_log.delete();
    hand_log.delete();
    rst = 1'b1;
  endtask

  // Returns at the negedge of the cycle in which a request is accepted.
  task automatic wait_fire(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(fif.imem_req_valid && fif.imem_req_ready) && n < 50);
    if (!(fif.imem_req_valid && fif.imem_req_ready)) begin
      checks++; errors++;
      $display("FAIL %s actual=no_request required=request_within_50_cycles", name);
    end
  endtask

  function automatic logic [64:0] hand_at(input int i);
    return (i < hand_log.size()) ? hand_log[i] : 65'h0;
  endfunction

  function automatic logic [31:0] addr_at(input int i);
    return (i < addr_log.size()) ? addr_log[i] : 32'h0;
  endfunction

  initial begin
    int n;
    logic found;
    rst = 1'b0;
    fif.id_allowin = 1'b0; fif.id_branch_taken = 1'b0; fif.id_branch_result = 32'h0;
    fif.csr_redirect_valid = 1'b0; fif.csr_redirect_pc = 32'h0; fif.imem_req_ready = 1'b1;

    // Sequential fetch with decode always accepting.
    fif.id_allowin = 1'b1; resp_lat = 1;
    do_reset();
    repeat (10) tick();
    chk("t1_nfetch", {64'h0, addr_log.size() >= 3}, 65'h1);
    chk("t1_addr0", {33'h0, addr_at(0)}, {33'h0, 32'h8000_0000});
    chk("t1_addr1", {33'h0, addr_at(1)}, {33'h0, 32'h8000_0004});
    chk("t1_addr2", {33'h0, addr_at(2)}, {33'h0, 32'h8000_0008});
    chk("t1_nhand", {64'h0, hand_log.size() >= 3}, 65'h1);
    chk("t1_bus0", hand_at(0), {1'b0, 32'h0000_0013, 32'h8000_0000});
    chk("t1_pc1", {33'h0, hand_at(1)[31:0]}, {33'h0, 32'h8000_0004});
    chk("t1_bus2", hand_at(2), {1'b1, 32'h0010_0073, 32'h8000_0008});

    // Decode stalled: response held in the buffer.
    fif.id_allowin = 1'b0;
    do_reset();
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(fif.if_to_id_valid && fif.if_instruction_blocked) && n < 50);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("t2_valid", {64'h0, fif.if_to_id_valid}, 65'h1);
      chk("t2_blocked", {64'h0, fif.if_instruction_blocked}, 65'h1);
      chk("t2_inst_reg", {33'h0, fif.if_instruction_reg}, {33'h0, 32'h0000_0013});
      chk("t2_pc", {33'h0, fif.imem_addr}, {33'h0, 32'h8000_0000});
    end
    tick();
    fif.id_allowin = 1'b1;
    wait_fire("t2_next_fire");
    chk("t2_next_addr", {33'h0, fif.imem_addr}, {33'h0, 32'h8000_0004});

    // Branch while waiting: stale response dropped, target low bits cleared.
    resp_lat = 3;
    do_reset();
    wait_fire("t3_first_fire");
    tick();
    fif.id_branch_taken = 1'b1; fif.id_branch_result = 32'h8000_0102;
    tick();
    fif.id_branch_taken = 1'b0;
    wait_fire("t3_target_fire");
    chk("t3_target_addr", {33'h0, fif.imem_addr}, {33'h0, 32'h8000_0100});
    repeat (8) tick();
    chk("t3_hand", hand_at(0), {1'b0, 32'h0010_0033, 32'h8000_0100});

    // CSR redirect and branch in the same cycle; CSR wins, flush pulses.
    resp_lat = 1;
    do_reset();
    wait_fire("t4_first_fire");
    tick();
    fif.csr_redirect_valid = 1'b1; fif.csr_redirect_pc = 32'h8000_0200;
    fif.id_branch_taken = 1'b1; fif.id_branch_result = 32'h8000_0300;
    @(negedge clk);
    chk("t4_flush_before", {64'h0, fif.if_flush}, 65'h0);
    tick();
    fif.csr_redirect_valid = 1'b0; fif.id_branch_taken = 1'b0;
    @(negedge clk);
    chk("t4_flush_pulse", {64'h0, fif.if_flush}, 65'h1);
    chk("t4_fire_addr", {32'h0, fif.imem_req_valid & fif.imem_req_ready, fif.imem_addr},
        {32'h0, 1'b1, 32'h8000_0200});
    chk("t4_no_hand", {33'h0, hand_log.size()}, 65'h0);
    @(negedge clk);
    chk("t4_flush_after", {64'h0, fif.if_flush}, 65'h0);

    // Reset while waiting; the response lands during reset.
    resp_lat = 2;
    do_reset();
    wait_fire("t5_first_fire");
    tick();
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("t5_rst_valid", {64'h0, fif.if_to_id_valid}, 65'h0);
    end
    tick();
    addr_log.delete(); hand_log.delete();
    rst = 1'b1;
    wait_fire("t5_post_fire");
    chk("t5_post_addr", {33'h0, fif.imem_addr}, {33'h0, 32'h8000_0000});
    repeat (4) tick();
    chk("t5_hand_pc", {33'h0, hand_at(0)[31:0]}, {33'h0, 32'h8000_0000});

    // PC wrap after a trap to the top of memory, with ready/allowin churn.
    addr_log.delete();
    fif.csr_redirect_valid = 1'b1; fif.csr_redirect_pc = 32'hFFFF_FFFE;
    tick();
    fif.csr_redirect_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      fif.imem_req_ready = (i % 3) != 1;
      fif.id_allowin     = (i % 4) != 3;
      resp_lat           = 1 + (i % 3);
      fif.id_branch_taken = (i == 45); fif.id_branch_result = 32'h8000_1000;
      tick();
    end
    fif.id_branch_taken = 1'b0; fif.imem_req_ready = 1'b1; fif.id_allowin = 1'b1;
    repeat (10) tick();
    found = 1'b0;
    for (int i = 0; i + 1 < addr_log.size(); i++)
      if (addr_log[i] == 32'hFFFF_FFFC && addr_log[i + 1] == 32'h0000_0000) found = 1'b1;
    chk("t6_wrap", {64'h0, found}, 65'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_22040127_fetch.md
Name: ysyx_22040127_fetch

Overview:
- IF stage of the 5-stage RV64 pipeline; the producer end of the IF->ID valid/allowin handshake consumed by decode.
- Owns the PC and issues one instruction-memory request at a time.
- Buffers the returned instruction while ID stalls, and applies redirects from ID branches and from CSR traps (ecall/mret).
- Drives the 65-bit if_to_id_bus {ebreak, inst[31:0], pc[31:0]}.

Parameters:
RESET_PC, 32'h8000_0000, first fetch address after reset
IF_TO_ID_WIDTH, 65, width of if_to_id_bus; must equal `IF_TO_ID_WIDTH

Ports:
clk  in  1  single clock, all state on posedge
rst  in  1  asynchronous, active-low reset
id_allowin  in  1  decode can accept this cycle
id_branch_taken  in  1  decode redirect (jal/jalr/taken B); decode keeps it low when its slot is invalid
id_branch_result  in  32  branch/jump target
csr_redirect_valid  in  1  trap/mret redirect from MEM/CSR
csr_redirect_pc  in  32  mtvec or mepc
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  32  request PC, word aligned
imem_resp_valid  in  1  response valid, at least 1 cycle after acceptance
imem_resp_data  in  32  instruction word
if_to_id_valid  out  1  bus holds a live instruction
if_to_id_bus  out  65  {ebreak, inst, pc}
if_instruction_reg  out  32  buffered instruction word
if_instruction_blocked  out  1  inst field is sourced from the buffer
if_flush  out  1  registered pulse: the instruction in flight was dropped by a CSR redirect

Behaviour:
- Reset (rst low, async): pc=RESET_PC, state=REQ. All outputs 0 except imem_addr=RESET_PC. imem_req_valid rises on the first clock edge after rst deasserts.
- States:
  - REQ: imem_req_valid=1, imem_addr=pc. On req_ready go to WAIT.
  - WAIT: wait for resp_valid.
    - If id_allowin: present the response combinationally with if_to_id_valid=1; pc+=4; go to REQ.
    - Else: latch the response into the buffer and go to HOLD.
  - HOLD: if_to_id_valid=1, if_instruction_blocked=1, inst field = if_instruction_reg. On id_allowin: pc+=4, go to REQ.
  - DROP: an accepted request is stale. Discard its response, then go to REQ at the new pc.
- ebreak bit = (inst == 32'h0010_0073).
- Redirect: next pc = csr_redirect_pc if csr_redirect_valid, else id_branch_result if (id_branch_taken & id_allowin).
  - Redirect in REQ (not accepted) or HOLD: buffer cleared, pc=target, state=REQ.
  - Redirect in WAIT without response: state=DROP, pc=target.
  - Redirect in WAIT with response: response discarded, if_to_id_valid forced 0, pc=target, state=REQ.
  - CSR redirect wins over a simultaneous branch.
  - if_flush=1 for exactly one cycle after any CSR redirect.
- pc arithmetic: 32-bit, wraps modulo 2^32. Bits [1:0] of targets are forced to 0.
- At most one outstanding request. imem_addr is stable while req_valid && !req_ready.
- Reset asserted mid-transaction: state returns to REQ immediately. A late response after reset release is ignored, because the state is not WAIT/DROP.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs perf_fetch_cnt[63:0] (instructions handed to ID), perf_stall_cnt[63:0] (cycles in HOLD), perf_redirect_cnt[63:0] (redirects applied). All are cleared by rst.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset release, memory ready, 1-cycle latency, id_allowin=1 -> addresses 8000_0000, 8000_0004, 8000_0008 in order; bus pc matches each; if_instruction_blocked=0.
- Response 32'h0000_0013 while id_allowin=0 for 3 cycles -> if_to_id_valid held, if_instruction_blocked=1, if_instruction_reg=32'h0000_0013, pc stays 8000_0000; after allowin, next addr 8000_0004.
- id_branch_taken=1, id_allowin=1, target 8000_0100 while in WAIT without response -> that response is dropped; next addr 8000_0100.
- csr_redirect_valid with pc 8000_0200 and id_branch_taken with 8000_0300 in the same cycle -> next addr 8000_0200; if_flush pulses once.
- Response 32'h0010_0073 -> bus bit 64 = 1.
- rst low while in WAIT, response arrives during reset -> no valid output; first post-reset addr = 8000_0000.
